// File: rtl/reg_wr_arbiter_if.sv
// Shared register write channel: one write pulse carrying address, data and bit mask.
interface reg_wrchan_if #(
    parameter int K_DWIDTH = 8,
    parameter int K_AWIDTH = 16
);
    logic                write;
    logic [K_AWIDTH-1:0] addr;
    logic [K_DWIDTH-1:0] data;
    logic [K_DWIDTH-1:0] bmask;

    modport master (output write, addr, data, bmask);
    modport slave  (input  write, addr, data, bmask);
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter merging K_NREQ register write requesters onto one write channel.
// Optional grant locking is compiled in when REG_WR_ARB_LOCK_EN is defined.
module reg_wr_arbiter #(
    parameter int K_NREQ    = 4,
    parameter int K_DWIDTH  = 8,
    parameter int K_AWIDTH  = 16,
    parameter int K_MAXLOCK = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [K_NREQ-1:0]                  i_req_valid,
    output logic [K_NREQ-1:0]                  o_req_ready,
    input  logic [K_NREQ-1:0][K_AWIDTH-1:0]    i_req_addr,
    input  logic [K_NREQ-1:0][K_DWIDTH-1:0]    i_req_data,
    input  logic [K_NREQ-1:0][K_DWIDTH-1:0]    i_req_bmask,
    input  logic [K_NREQ-1:0]                  i_req_lock,
    reg_wrchan_if.master                       wr,
    output logic [$clog2(K_NREQ)-1:0]          o_grant_id
);

    localparam int IW = $clog2(K_NREQ);

    logic [IW-1:0] last;
    logic          rr_hit;
    logic [IW-1:0] rr_idx;
    logic          gnt_hit;
    logic [IW-1:0] gnt_idx;
    logic          accept;

    // Search order starts just after the last granted requester and wraps.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 1; k <= K_NREQ; k++) begin
            if (!rr_hit && i_req_valid[(32'(last) + k) % K_NREQ]) begin
                rr_hit = 1'b1;
                rr_idx = IW'((32'(last) + k) % K_NREQ);
            end
        end
    end

`ifdef REG_WR_ARB_LOCK_EN
    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } lock_state_t;

    lock_state_t   state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [7:0]    cnt, cnt_nx;
    logic          lock_grant;

    assign lock_grant = (state == S_LOCKED) && i_req_valid[owner];

    always_comb begin
        gnt_hit = rr_hit;
        gnt_idx = rr_idx;
        if (lock_grant) begin
            gnt_hit = 1'b1;
            gnt_idx = owner;
        end
    end

    // Owner dropping valid ends the lock in the same cycle; round-robin then
    // arbitrates, and a new locked acceptance may immediately re-enter LOCKED.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        cnt_nx   = cnt;
        if (lock_grant) begin
            if (!i_req_lock[owner] || cnt == 8'(K_MAXLOCK - 1)) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 8'd1;
            end
        end else begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            if (accept && i_req_lock[gnt_idx] && K_MAXLOCK > 1) begin
                state_nx = S_LOCKED;
                owner_nx = gnt_idx;
                cnt_nx   = 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            cnt   <= cnt_nx;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^i_req_lock;

    always_comb begin
        gnt_hit = rr_hit;
        gnt_idx = rr_idx;
    end
`endif

    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && gnt_hit) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept = |o_req_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr.write   <= 1'b0;
            wr.addr    <= '0;
            wr.data    <= '0;
            wr.bmask   <= '0;
            o_grant_id <= '0;
            last       <= IW'(K_NREQ - 1);
        end else begin
            wr.write <= accept;
            if (accept) begin
                wr.addr    <= i_req_addr[gnt_idx];
                wr.data    <= i_req_data[gnt_idx];
                wr.bmask   <= i_req_bmask[gnt_idx];
                o_grant_id <= gnt_idx;
                last       <= gnt_idx;
            end
        end
    end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 SHALL have parameter K_NREQ, default 4, number of write requesters (2..16).
REQ-002 SHALL have parameter K_DWIDTH, default 8, register data and bit-mask width.
REQ-003 SHALL have parameter K_AWIDTH, default 16, register address width.
REQ-004 SHALL have parameter K_MAXLOCK, default 4, maximum consecutive grants under lock (1..255).
REQ-005 SHALL have port i_clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_req_valid, input, K_NREQ, per-requester write request.
REQ-008 SHALL have port o_req_ready, output, K_NREQ, per-requester accept; one-hot or zero.
REQ-009 SHALL have port i_req_addr, input, K_NREQ x K_AWIDTH, per-requester write address.
REQ-010 SHALL have port i_req_data, input, K_NREQ x K_DWIDTH, per-requester write data.
REQ-011 SHALL have port i_req_bmask, input, K_NREQ x K_DWIDTH, per-requester bit mask.
REQ-012 SHALL have port i_req_lock, input, K_NREQ, per-requester lock request (used only with lock feature).
REQ-013 SHALL have port wr, reg_wrchan_if master modport, K_DWIDTH/K_AWIDTH, shared register write channel.
REQ-014 SHALL have port o_grant_id, output, $clog2(K_NREQ), index of requester that produced the current wr.write pulse.

Function
REQ-015 SHALL accept at most one request per cycle: o_req_ready[g]=1 combinationally for the single granted g with i_req_valid[g]=1; transfer occurs when valid&ready.
REQ-016 SHALL assert no o_req_ready bit when no i_req_valid bit is set.
REQ-017 SHALL arbitrate round-robin: search starts at index (last granted + 1) mod K_NREQ, wrapping past K_NREQ-1 to 0.
REQ-018 SHALL register the accepted addr/data/bmask and pulse wr.write for exactly one cycle on the cycle after acceptance (latency 1).
REQ-019 SHALL sustain one write per cycle; back-to-back acceptances produce consecutive wr.write pulses.
REQ-020 SHALL hold wr.addr, wr.data, wr.bmask and o_grant_id at their last values when wr.write=0.
REQ-021 SHALL update the round-robin pointer only on an accepted transfer.
REQ-022 SHALL treat the write channel as always accepting; no backpressure from the slave.
REQ-023 SHALL ignore request inputs of non-granted requesters; requester whose valid drops before acceptance loses nothing.

Reset
REQ-024 SHALL, while i_rst_n=0, force wr.write=0, wr.addr=0, wr.data=0, wr.bmask=0, o_grant_id=0, lock state idle, lock counter 0, last-granted pointer K_NREQ-1 (requester 0 highest priority first).
REQ-025 SHALL drop any accepted-but-not-yet-written transfer when reset asserts mid-operation; no wr.write pulse follows reset release without a new acceptance.
REQ-026 SHALL drive o_req_ready=0 during reset.

Configuration
REQ-027 SHALL implement grant locking only when macro REG_WR_ARB_LOCK_EN is defined.
REQ-028 With REG_WR_ARB_LOCK_EN: state LOCKED entered when a transfer is accepted with i_req_lock[g]=1; in LOCKED, g has absolute priority while i_req_valid[g]=1.
REQ-029 With REG_WR_ARB_LOCK_EN: lock counter counts accepted transfers in LOCKED; on the K_MAXLOCK-th locked grant, or acceptance with i_req_lock[g]=0, or a cycle with i_req_valid[g]=0, return to IDLE and resume round-robin after g.
REQ-030 Without REG_WR_ARB_LOCK_EN: i_req_lock ignored, no lock state or counter synthesised, pure round-robin.

Verification
REQ-031 Reset release, i_req_valid=0001, addr 0x0010 data 0xA5 bmask 0xFF -> ready[0] same cycle, next cycle wr.write=1 addr 0x0010 data 0xA5, o_grant_id=0.
REQ-032 i_req_valid=1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; wr.write high 8 consecutive cycles, one cycle late.
REQ-033 i_req_valid=1010 after last grant 3 -> grant 1 then 3 then 1 (wrap-around 3->1).
REQ-034 Reset asserted the cycle after accepting requester 2 -> no wr.write pulse; all outputs 0; first grant after release is requester 0.
REQ-035 REG_WR_ARB_LOCK_EN, K_MAXLOCK=4, requesters 0 and 1 valid, lock[0]=1 -> grants 0,0,0,0,1 then round-robin.
REQ-036 REG_WR_ARB_LOCK_EN undefined, same stimulus as REQ-035 -> grants 0,1,0,1,0.
